// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined MAC: mode codes, beat-counter states, saturation limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_DOT    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } fsm_state_e;

    // Largest representable value of a width-bit result; callers size-cast to their width.
    function automatic logic [63:0] sat_max(input int width, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        if (sgn) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    // Smallest representable value of a width-bit result; callers size-cast to their width.
    function automatic logic [63:0] sat_min(input int width, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        if (sgn) begin
            return ~((one << (width - 1)) - one);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Saturating adder: W+1 bit add of two W-bit operands, clamped back to W bits with overflow flag.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int W   = 20,
    parameter bit SGN = 1'b0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W, SGN));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W, SGN));

    logic [W:0] a_x;
    logic [W:0] b_x;
    logic [W:0] raw;

    // Extend by one bit so the true sum is exact, then clamp if it does not fit in W bits.
    always_comb begin
        a_x   = SGN ? {a_i[W-1], a_i} : {1'b0, a_i};
        b_x   = SGN ? {b_i[W-1], b_i} : {1'b0, b_i};
        raw   = a_x + b_x;
        sum_o = raw[W-1:0];
        ovf_o = 1'b0;
        if (SGN) begin
            if (raw[W] != raw[W-1]) begin
                ovf_o = 1'b1;
                sum_o = raw[W] ? MIN_V : MAX_V;
            end
        end else if (raw[W]) begin
            ovf_o = 1'b1;
            sum_o = MAX_V;
        end
    end

endmodule

// File: rtl/mac_pipe_acc.sv
// Two-stage MAC: stage 1 multiplies, stage 2 adds/accumulates with saturation (single or dot-product mode).
// Latency: result valid 2 cycles after the accepting (or last dot-product) beat; 1 beat/cycle.
// Backpressure: one global stall (out_valid && !out_ready) freezes both stages and drops in_ready.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int VEC_LEN    = 4,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam bit SGN   = (SIGNED != 0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    // Beat counter FSM
    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat_first, beat_last, beat_mode;

    logic stall;
    logic accept;

    // Stage 1 registers
    logic                  s1_vld_q;
    logic [PW-1:0]         s1_p_q;
    logic [DATA_WIDTH-1:0] s1_c_q;
    logic                  s1_mode_q;
    logic                  s1_first_q;
    logic                  s1_last_q;

    // Stage 2 / output registers
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_acc_q;
    logic                 out_vld_q;
    logic [ACC_WIDTH-1:0] out_q;
    logic                 ovf_q;

    logic [PW-1:0]        a_x, b_x, prod;
    logic [ACC_WIDTH-1:0] c_ext, p_ext, add_a, sum;
    logic                 sum_ovf, ovf_run;

    assign stall     = out_vld_q && !out_ready;
    assign in_ready  = !reset && !stall;
    assign accept    = in_valid && in_ready;
    assign busy      = (cnt_q != '0);
    assign out_valid = out_vld_q;
    assign out       = out_q;
    assign overflow  = ovf_q;

    // Beat counter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Classify the offered beat (first/last/mode) and advance the counter on acceptance
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_first = 1'b1;
        beat_last  = 1'b1;
        beat_mode  = mode;
        case (state_q)
            IDLE: begin
                if (mode == MODE_DOT) begin
                    beat_last = (VEC_LEN == 1);
                    if (accept && (VEC_LEN > 1)) begin
                        state_d = ACCUM;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ACCUM: begin
                // mode and c are ignored mid-vector
                beat_first = 1'b0;
                beat_mode  = MODE_DOT;
                beat_last  = (cnt_q == LAST_CNT);
                if (accept) begin
                    if (beat_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Full-width product: low PW bits of extended operands give the exact signed/unsigned result
    always_comb begin
        a_x  = SGN ? PW'($signed(a)) : PW'(a);
        b_x  = SGN ? PW'($signed(b)) : PW'(b);
        prod = a_x * b_x;
    end

    // Stage 1: capture product and beat tags; frozen while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_p_q     <= '0;
            s1_c_q     <= '0;
            s1_mode_q  <= MODE_SINGLE;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (!stall) begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_p_q     <= prod;
                s1_c_q     <= c;
                s1_mode_q  <= beat_mode;
                s1_first_q <= beat_first;
                s1_last_q  <= beat_last;
            end
        end
    end

    // Stage 2 operands: first beat seeds from c, later beats continue from the (possibly clamped) accumulator
    always_comb begin
        c_ext   = SGN ? ACC_WIDTH'($signed(s1_c_q)) : ACC_WIDTH'(s1_c_q);
        p_ext   = SGN ? ACC_WIDTH'($signed(s1_p_q)) : ACC_WIDTH'(s1_p_q);
        add_a   = s1_first_q ? c_ext : acc_q;
        ovf_run = sum_ovf || (!s1_first_q && ovf_acc_q);
    end

    mac_sat_add #(
        .W   (ACC_WIDTH),
        .SGN (SGN)
    ) u_sat_add (
        .a_i   (add_a),
        .b_i   (p_ext),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    // Stage 2: update accumulator for dot beats, publish result on last beat; hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (!stall) begin
            if (s1_vld_q && (s1_mode_q == MODE_DOT)) begin
                acc_q     <= sum;
                ovf_acc_q <= ovf_run;
            end
            out_vld_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q && s1_last_q) begin
                out_q <= sum;
                ovf_q <= ovf_run;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_acc.sv
module tb_mac_pipe_acc;

    localparam int VL   = 4;
    localparam int UMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Unsigned instance: DATA_WIDTH=2, ACC_WIDTH=4
    logic       u_in_valid, u_in_ready, u_mode, u_out_valid, u_out_ready, u_overflow, u_busy;
    logic [1:0] u_a, u_b, u_c;
    logic [3:0] u_out;

    // Signed instance: DATA_WIDTH=4, ACC_WIDTH=8
    logic       s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready, s_overflow, s_busy;
    logic [3:0] s_a, s_b, s_c;
    logic [7:0] s_out;

    mac_pipe_acc #(.DATA_WIDTH(2), .ACC_WIDTH(4), .VEC_LEN(VL), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .a(u_a), .b(u_b), .c(u_c), .mode(u_mode), .out_valid(u_out_valid),
        .out_ready(u_out_ready), .out(u_out), .overflow(u_overflow), .busy(u_busy)
    );

    mac_pipe_acc #(.DATA_WIDTH(4), .ACC_WIDTH(8), .VEC_LEN(VL), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .c(s_c), .mode(s_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out(s_out), .overflow(s_overflow), .busy(s_busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: results derived from accepted beats with plain integer arithmetic
    typedef struct {
        int val;
        bit ovf;
    } res_t;

    res_t       exp_q[$];
    res_t       m_e;
    bit         in_vec;
    int         vec_c;
    int         prods[$];
    bit         prev_stall;
    logic [3:0] prev_out;
    logic       prev_ovf;

    task automatic model_beat(input int a, input int b, input int c, input bit m);
        int   acc;
        bit   ov;
        res_t r;
        if (!in_vec && !m) begin
            acc = a * b + c;
            ov  = 0;
            if (acc > UMAX) begin acc = UMAX; ov = 1; end
            r.val = acc; r.ovf = ov;
            exp_q.push_back(r);
        end else begin
            if (!in_vec) begin
                in_vec = 1;
                vec_c  = c;
                prods.delete();
            end
            prods.push_back(a * b);
            if (prods.size() == VL) begin
                acc = vec_c;
                ov  = 0;
                foreach (prods[i]) begin
                    acc += prods[i];
                    if (acc > UMAX) begin acc = UMAX; ov = 1; end
                end
                r.val = acc; r.ovf = ov;
                exp_q.push_back(r);
                in_vec = 0;
            end
        end
    endtask

    // Monitor: score every delivered result and check output hold under backpressure
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prods.delete();
            in_vec     = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", u_out_valid, 1);
                chk("hold_out", u_out, prev_out);
                chk("hold_ovf", u_overflow, prev_ovf);
            end
            if (u_out_valid && u_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", u_out_valid, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("res_out", u_out, m_e.val);
                    chk("res_ovf", u_overflow, m_e.ovf);
                end
            end
            if (u_in_valid && u_in_ready)
                model_beat(int'(u_a), int'(u_b), int'(u_c), u_mode);
            prev_stall = u_out_valid && !u_out_ready;
            prev_out   = u_out;
            prev_ovf   = u_overflow;
        end
    end

    task automatic send(input int a, input int b, input int c, input bit m);
        bit acc;
        acc = 0;
        u_in_valid = 1; u_a = 2'(a); u_b = 2'(b); u_c = 2'(c); u_mode = m;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = u_in_ready;
            @(posedge clk); #1;
        end
        chk("send_accepted", acc, 1);
        u_in_valid = 0;
    endtask

    task automatic wait_result(input int expv, input int expo, input string tag);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (u_out_valid) break;
        end
        chk({tag, "_vld"}, u_out_valid, 1);
        chk({tag, "_out"}, u_out, expv);
        chk({tag, "_ovf"}, u_overflow, expo);
        @(posedge clk); #1;
    endtask

    // Signed dot product: 4 identical beats, seed c on the first; result expected in cycle 5
    task automatic sdot(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input int expv, input int expo, input string tag);
        for (int cyc = 0; cyc < 8; cyc++) begin
            s_in_valid = (cyc < 4);
            s_mode = 1; s_a = a; s_b = b;
            s_c = (cyc == 0) ? c : 4'h0;
            @(negedge clk);
            chk({tag, "_vld"}, s_out_valid, (cyc == 5));
            if (cyc == 5) begin
                chk({tag, "_out"}, s_out, expv);
                chk({tag, "_ovf"}, s_overflow, expo);
            end
            @(posedge clk); #1;
        end
        s_in_valid = 0;
    endtask

    int m0_a[4]   = '{3, 1, 1, 3};
    int m0_b[4]   = '{1, 3, 1, 3};
    int m0_c[4]   = '{3, 0, 1, 3};
    int m0_exp[4] = '{6, 3, 2, 12};
    int bp_a[3]   = '{2, 3, 1};
    int bp_b[3]   = '{3, 3, 2};
    int bp_c[3]   = '{1, 2, 0};
    int bp_exp[3] = '{7, 11, 2};
    int got[$];
    int idx;

    initial begin
        reset = 1;
        u_in_valid = 0; u_a = 0; u_b = 0; u_c = 0; u_mode = 0; u_out_ready = 1;
        s_in_valid = 0; s_a = 0; s_b = 0; s_c = 0; s_mode = 0; s_out_ready = 1;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", u_in_ready, 0);
        chk("rst_out_valid", u_out_valid, 0);
        chk("rst_out", u_out, 0);
        chk("rst_ovf", u_overflow, 0);
        chk("rst_busy", u_busy, 0);
        reset = 0;
        #1;
        chk("post_rst_in_ready", u_in_ready, 1);

        // Mode 0 back-to-back beats
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc < 4) begin
                u_in_valid = 1; u_mode = 0;
                u_a = 2'(m0_a[cyc]); u_b = 2'(m0_b[cyc]); u_c = 2'(m0_c[cyc]);
            end else begin
                u_in_valid = 0;
            end
            @(negedge clk);
            chk("m0_vld", u_out_valid, (cyc >= 2 && cyc < 6));
            if (cyc >= 2 && cyc < 6) begin
                chk("m0_out", u_out, m0_exp[cyc-2]);
                chk("m0_ovf", u_overflow, 0);
            end
            @(posedge clk); #1;
        end

        // Dot product c=1, four (1,1) beats; later beats carry junk c/mode that must be ignored
        for (int cyc = 0; cyc < 8; cyc++) begin
            u_in_valid = (cyc < 4);
            u_a = 1; u_b = 1;
            u_c = (cyc == 0) ? 2'd1 : 2'd3;
            u_mode = (cyc == 0);
            @(negedge clk);
            chk("dot_busy", u_busy, (cyc >= 1 && cyc <= 3));
            chk("dot_vld", u_out_valid, (cyc == 5));
            if (cyc == 5) begin
                chk("dot_out", u_out, 5);
                chk("dot_ovf", u_overflow, 0);
            end
            @(posedge clk); #1;
        end
        u_in_valid = 0;

        // Saturation then sticky-overflow clear on the next vector
        repeat (4) send(3, 3, 0, 1);
        wait_result(15, 1, "sat");
        repeat (4) send(1, 1, 0, 1);
        wait_result(4, 0, "post_sat");

        // Backpressure: three mode-0 beats against a blocked consumer
        idx = 0;
        got.delete();
        u_out_ready = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 6) u_out_ready = 1;
            u_in_valid = (idx < 3);
            u_mode = 0;
            if (idx < 3) begin
                u_a = 2'(bp_a[idx]); u_b = 2'(bp_b[idx]); u_c = 2'(bp_c[idx]);
            end
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_in_ready", u_in_ready, 0);
                chk("bp_out_hold", u_out, 7);
                chk("bp_vld_hold", u_out_valid, 1);
            end
            if (u_out_valid && u_out_ready) got.push_back(int'(u_out));
            if (u_in_valid && u_in_ready) idx++;
            @(posedge clk); #1;
        end
        u_in_valid = 0;
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], bp_exp[i]);

        // Reset in the middle of a vector
        send(2, 2, 3, 1);
        send(2, 2, 0, 1);
        @(negedge clk);
        chk("mid_busy", u_busy, 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("mid_rst_busy", u_busy, 0);
        chk("mid_rst_vld", u_out_valid, 0);
        chk("mid_rst_in_ready", u_in_ready, 1);
        @(posedge clk); #1;
        repeat (4) send(1, 1, 0, 1);
        wait_result(4, 0, "fresh_vec");

        // Randomized traffic with random backpressure, scored by the monitor
        for (int i = 0; i < 600; i++) begin
            u_in_valid  = ($urandom_range(0, 3) != 0);
            u_a         = 2'($urandom_range(0, 3));
            u_b         = 2'($urandom_range(0, 3));
            u_c         = 2'($urandom_range(0, 3));
            u_mode      = 1'($urandom_range(0, 1));
            u_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        u_in_valid  = 0;
        u_out_ready = 1;
        repeat (10) begin @(posedge clk); #1; end
        chk("rand_drain", exp_q.size(), 0);

        // Signed instance
        for (int cyc = 0; cyc < 4; cyc++) begin
            s_in_valid = (cyc == 0);
            s_mode = 0; s_a = 4'h8; s_b = 4'h8; s_c = 4'h7;
            @(negedge clk);
            chk("s_m0_vld", s_out_valid, (cyc == 2));
            if (cyc == 2) begin
                chk("s_m0_out", s_out, 71);
                chk("s_m0_ovf", s_overflow, 0);
            end
            @(posedge clk); #1;
        end
        s_in_valid = 0;
        sdot(4'h8, 4'h7, 4'h8, 8'h80, 1, "s_dot_sat");
        sdot(4'hF, 4'h3, 4'h2, 8'hF6, 0, "s_dot_neg");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_pipe_acc.md
Name: mac_pipe_acc

Overview:
- Parameterised, 2-stage pipelined multiply-accumulate unit; successor to the single-cycle a*b+c MAC.
- Adds a valid/ready handshake on both sides, signed/unsigned operands, saturating output with an overflow flag, and a dot-product mode that accumulates VEC_LEN products before emitting one result.
- Sits between operand streams (buffers/FIFOs) and result consumers in the datapath.

Parameters:
- DATA_WIDTH, 8: width of a, b, c.
- ACC_WIDTH, 20: width of the accumulator and of out; must be >= 2*DATA_WIDTH.
- VEC_LEN, 4: products per dot-product result in mode 1; allowed range 1..256.
- SIGNED, 0: 0 = unsigned operands and result; 1 = two's-complement operands and result.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  DATA_WIDTH  multiplicand.
- b  in  DATA_WIDTH  multiplier.
- c  in  DATA_WIDTH  addend (mode 0) or accumulator seed (mode 1, first beat only).
- mode  in  1  0 = single a*b+c; 1 = dot product over VEC_LEN beats.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  ACC_WIDTH  saturated result.
- overflow  out  1  result was clamped; qualified by out_valid.
- busy  out  1  partial dot product in progress (beat count != 0).

Behaviour:
- Reset: out_valid=0, out=0, overflow=0, busy=0, in_ready=0 during the reset cycle and 1 on the following cycle. All pipeline valids, the accumulator and the beat counter clear; any partial vector is discarded.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Stall: in_ready = !(out_valid && !out_ready). A single global stall freezes every stage; no beat is dropped or duplicated.
- Stage 1: registers the product p = a*b at 2*DATA_WIDTH bits (signed multiply when SIGNED=1), plus c, mode, a first flag and a last flag.
- Stage 2: computes at ACC_WIDTH+1 bits, then saturates to ACC_WIDTH:
  - mode 0: out = p + c.
  - mode 1, first beat: acc = c + p.
  - mode 1, later beats: acc = acc + p.
  - For mode 1, out and out_valid update only on the last beat.
- Latency:
  - mode 0: out_valid rises 2 cycles after acceptance.
  - mode 1: out_valid rises 2 cycles after the VEC_LEN-th beat is accepted.
  - Throughput is 1 beat/cycle when not stalled.
- FSM (beat counter):
  - IDLE (count=0): an accepted beat with mode=1 latches the mode and goes to ACCUM with count=1. If VEC_LEN=1, the beat is also last and the FSM stays in IDLE. A mode=0 beat stays in IDLE.
  - ACCUM: each accepted beat increments count. When count reaches VEC_LEN-1, that beat is marked last, count returns to 0 and the FSM returns to IDLE.
  - The mode input is ignored while in ACCUM. c is ignored on non-first beats.
- Saturation:
  - Unsigned: results above 2^ACC_WIDTH-1 clamp to all-ones.
  - Signed: results clamp to the ACC_WIDTH signed max/min.
  - A clamped intermediate keeps accumulating from the clamped value.
  - overflow is sticky across one dot product and clears on the next first beat.
- Output hold: out, overflow and out_valid hold stable until out_ready. A result and out_ready in the same cycle pass through with no bubble.
- Sign handling: c is sign-extended when SIGNED=1, zero-extended otherwise.

Decomposition:
- Shared package mac_pkg:
  - MODE_SINGLE = 1'b0, MODE_DOT = 1'b1.
  - FSM state encodings IDLE and ACCUM.
  - Saturation limit functions (sat_max, sat_min) parameterised by width and signedness.
- Sub-module mac_sat_add: combinational (ACC_WIDTH+1)-bit add, saturate and overflow flag. Reused by stage 2.

Test Plan (DATA_WIDTH=2, ACC_WIDTH=4, VEC_LEN=4, SIGNED=0 unless noted):
- Mode 0, out_ready=1: back-to-back beats (3,1,3), (1,3,0), (1,1,1), (3,3,3) -> out = 6, 3, 2, 12 on consecutive cycles, the first 2 cycles after acceptance; overflow=0.
- Mode 1: c=1, then four beats of a=1, b=1 -> one out_valid pulse with out=5, exactly 2 cycles after the 4th beat. busy is high from after beat 1 until after beat 4.
- Saturation, mode 1: four beats of a=3, b=3, c=0 -> out=15, overflow=1. The next vector (1,1,c=0) x4 -> out=4, overflow=0.
- Backpressure: out_ready=0 with 3 mode-0 beats offered -> in_ready drops once out_valid=1, out holds its first value, no beat is lost. Releasing out_ready gives all 3 results in order.
- Reset mid-vector: assert reset after 2 of 4 mode-1 beats -> out_valid=0 and busy=0 next cycle. A fresh 4-beat vector of (1,1,c=0) yields out=4.
- Signed, SIGNED=1, DATA_WIDTH=4, ACC_WIDTH=8: mode 0 with a=-8, b=-8, c=7 -> 71. Mode 1 with (-8)*(7) x4, c=-8 -> clamps to -128, overflow=1.
